// File: rtl/mini_alu_pkg.sv
// Shared constants, state encoding and function codes for the Mini ALU.
// Used by the sweeper and by the output mux.
package mini_alu_pkg;

   localparam int DATA_W = 6;
   localparam int FXN_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   localparam logic [FXN_W-1:0] FXN_ADD = 3'd0;
   localparam logic [FXN_W-1:0] FXN_SUB = 3'd1;
   localparam logic [FXN_W-1:0] FXN_AND = 3'd2;
   localparam logic [FXN_W-1:0] FXN_OR  = 3'd3;
   localparam logic [FXN_W-1:0] FXN_XOR = 3'd4;
   localparam logic [FXN_W-1:0] FXN_NOT = 3'd5;
   localparam logic [FXN_W-1:0] FXN_SHL = 3'd6;
   localparam logic [FXN_W-1:0] FXN_CMP = 3'd7;

endpackage

// File: rtl/mini_alu_sweeper.sv
// Steps the Mini ALU through every function code for one latched
// operand pair and streams each result out over valid/ready.
module mini_alu_sweeper
   import mini_alu_pkg::*;
#(
   parameter int NUM_FXN       = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic [FXN_W-1:0]  fxn_code,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [FXN_W-1:0]  res_fxn,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [FXN_W-1:0] LAST_FXN = FXN_W'(NUM_FXN - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         fxn_code  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         res_data  <= '0;
         res_fxn   <= '0;
         res_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  alu_a    <= a_in;
                  alu_b    <= b_in;
                  fxn_code <= FXN_ADD;
                  cnt      <= CNT_LOAD;
                  state    <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  res_data  <= alu_result;
                  res_fxn   <= fxn_code;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               // everything feeding res_data stays frozen until accepted
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  if (fxn_code == LAST_FXN) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     fxn_code <= fxn_code + 1'b1;
                     cnt      <= CNT_LOAD;
                     state    <= SETTLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mini_alu_sweeper.md
# mini_alu_sweeper

Sequential driver and result collector for the Mini ALU datapath. On a start pulse it latches two 6-bit operands, then steps the ALU function code through every code from 0 to NUM_FXN-1. For each code it holds the ALU inputs stable for a settle window, registers the ALU's final output, and hands the result downstream over a valid/ready handshake tagged with its function code. It sits between the operand source (switches or test sequencer) and the combinational Mini ALU / output mux, driving the mux inputs and consuming its output.

## Interface
- NUM_FXN, 8, number of function codes swept (1..8)
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture (>=1)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a sweep; sampled only in IDLE
- a_in  in  6  operand A, latched on accepted start
- b_in  in  6  operand B, latched on accepted start
- fxn_code  out  3  function code to ALU / output mux
- alu_a  out  6  registered operand A to ALU
- alu_b  out  6  registered operand B to ALU
- alu_result  in  6  ALU final output (combinational from fxn_code/alu_a/alu_b)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  6  captured ALU result
- res_fxn  out  3  function code res_data belongs to
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse after last result accepted

## Operation
- States: IDLE, SETTLE, HOLD.
- IDLE: busy=0. start=1 at an edge: alu_a<=a_in, alu_b<=b_in, fxn_code<=0, settle counter<=SETTLE_CYCLES-1, go SETTLE.
- SETTLE: counter decrements each edge. At the edge where counter==0: res_data<=alu_result, res_fxn<=fxn_code, res_valid<=1, go HOLD.
- HOLD: res_data, res_fxn, fxn_code, alu_a and alu_b are frozen until res_valid && res_ready at an edge. At that edge res_valid<=0, then:
  - if fxn_code==NUM_FXN-1: go IDLE, done<=1.
  - otherwise fxn_code<=fxn_code+1, counter reloads, go SETTLE.
- done is high for exactly one cycle; busy is 0 in that same cycle.
- busy = (state != IDLE).
- start while busy is ignored and is not queued.
- start in the same cycle done is high is accepted (state is IDLE).
- fxn_code never wraps past NUM_FXN-1 within a sweep.
- Operand changes on a_in/b_in after latch have no effect until the next accepted start.
- Widths: all data paths are 6 bits, no extension. The ALU comparator's 1-bit result arrives in alu_result bit 0 with bits 5:1 at zero, as the mux defines; the sweeper passes it through unchanged.

## Timing
- Reset values: fxn_code=0, alu_a=0, alu_b=0, res_data=0, res_fxn=0, res_valid=0, busy=0, done=0, state IDLE.
- Reset mid-sweep: all outputs return to reset values at the next edge. No done pulse; any pending result is dropped.
- Edge e0 is the edge that accepts start. Result k is captured at edge e0 + k·(SETTLE_CYCLES+1) + SETTLE_CYCLES when res_ready is held high.
- Per-code cost is SETTLE_CYCLES+1 cycles with ready high; each cycle of ready low adds one cycle.
- With defaults and ready high: res_valid is high after e1, e3, …, e15; done is high after e16; the sweep takes 16 cycles.
- res_valid never drops without a handshake. res_data is stable while res_valid=1.
- alu_result is sampled only on the capture edge; it needs to settle within one clock of a fxn_code change.

## Structure
- Shared package mini_alu_pkg holds:
  - DATA_W=6 and FXN_W=3 constants;
  - the state enum (IDLE/SETTLE/HOLD);
  - function-code localparams used by both the output mux and the sweeper.
- No sub-module needed inside the block. Integration is a wrapper mini_alu_top that instantiates mini_alu_sweeper plus output_mux and the arithmetic units.

## Test plan
- Bench ALU model: alu_result = {fxn_code, fxn_code} ^ alu_a.
- Reset then idle: all outputs 0 for 5 cycles with start=0.
- a_in=6'b000111, b_in=6'b011000, start pulse, res_ready=1 -> 8 results res_fxn 0..7, res_data={k,k}^6'b000111, valid after e1,e3,…,e15, done one cycle after e16, busy low with done.
- Backpressure: res_ready low for 4 cycles during fxn 3 -> res_data/res_fxn/fxn_code frozen, no result lost or duplicated, sweep ends 4 cycles later.
- start pulsed again at fxn 2 with a_in=6'b111111 -> ignored, results still use 6'b000111.
- reset asserted in HOLD at fxn 5 -> next cycle all outputs 0, no done; a new start then sweeps from fxn 0.
- SETTLE_CYCLES=3, NUM_FXN=4 -> results at e3,e7,e11,e15, done after e16 (ready high).
